snake_game_seq: RTL and testbench
=================================

SNAKE_GAME_SEQ -- requirements
Module: snake_game_seq

Interface
REQ-001 Parameter TICK_DIV, default 25000000, base clock cycles per game step.
REQ-002 Parameter MIN_DIV, default 5000000, lower bound on step period.
REQ-003 Parameter SPEED_STEP, default 2500000, period reduction per speed level.
REQ-004 Parameter APPLES_PER_LEVEL, default 4, apples eaten per speed-level increment.
REQ-005 Parameter SCORE_W, default 8, score width.
REQ-006 clk  input  1  system clock; single clock domain.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  one-cycle pulse; starts a game, or clears a finished one.
REQ-009 pause  input  1  level; freezes step timing while high.
REQ-010 dir_req_valid  input  1  one-cycle pulse qualifying dir_req.
REQ-011 dir_req  input  2  requested direction: 00 right, 01 down, 10 up, 11 left.
REQ-012 collision  input  1  head hit wall or body; sampled only in CHECK.
REQ-013 apple_eaten  input  1  head on apple; sampled only in CHECK.
REQ-014 step  output  1  one-cycle pulse advancing all snake cells.
REQ-015 cur_dir  output  2  direction applied on the current step.
REQ-016 grow  output  1  one-cycle pulse incrementing snake size.
REQ-017 score  output  SCORE_W  apples eaten this game.
REQ-018 speed_level  output  4  current speed level.
REQ-019 game_over  output  1  high while in OVER.

Function
REQ-020 The FSM SHALL have states IDLE, RUN, MOVE, CHECK and OVER.
REQ-021 IDLE -> RUN on start; the step counter SHALL load 0.
REQ-022 In RUN the counter SHALL increment each cycle pause is low, and hold while pause is high.
REQ-023 When the counter equals period-1 with pause low: RUN -> MOVE and the counter clears.
REQ-024 MOVE SHALL last exactly one cycle, asserting step and loading cur_dir from the pending direction; MOVE -> CHECK.
REQ-025 CHECK SHALL last exactly one cycle.
- collision=1 -> OVER.
- else apple_eaten=1 -> grow=1 for that cycle, score increments, -> RUN.
- else -> RUN.
REQ-026 When collision and apple_eaten are both high in CHECK, collision SHALL win: no grow, no score change.
REQ-027 OVER SHALL hold game_over=1 and ignore everything except start; start -> IDLE, clearing score and speed_level.
REQ-028 start SHALL be ignored in RUN, MOVE and CHECK.
REQ-029 A dir_req_valid SHALL update the pending direction in any state except OVER, unless dir_req is the opposite of cur_dir (right/left, up/down), in which case it is dropped.
REQ-030 With several valid requests between steps, the last accepted request SHALL win.
REQ-031 score SHALL saturate at all ones and never wrap.
REQ-032 Latency from the final counted cycle to step SHALL be one cycle. With pause low, step period = period+2 cycles.

Reset
REQ-033 On reset_n low, asynchronously:
- state IDLE, counter 0
- cur_dir and pending direction 00
- step, grow, game_over 0
- score 0, speed_level 0
REQ-034 Reset mid-game SHALL abandon the game with no further step or grow pulse.

Configuration
REQ-035 Macro SNAKE_SPEEDUP_EN.
- Defined: speed_level increments, saturating at 15, on every APPLES_PER_LEVEL-th grow. period = max(MIN_DIV, TICK_DIV - speed_level*SPEED_STEP), computed at 32 bits.
- Undefined: period = TICK_DIV and speed_level is tied to 0.

Structure
REQ-036 Package snake_pkg SHALL hold dir_t (2-bit enum), the seq_state_t enum and an opposite-direction function.
REQ-037 The step counter and period computation SHALL be sub-module snake_step_timer, with outputs tick and period.

Verification (TICK_DIV=4, MIN_DIV=2, SPEED_STEP=1, APPLES_PER_LEVEL=2)
REQ-038 Reset, then start -> step pulses every 6 cycles, cur_dir=00, score=0.
REQ-039 dir_req=11 while cur_dir=00 -> dropped. Then dir_req=01 followed by dir_req=10 -> next step shows cur_dir=10.
REQ-040 apple_eaten in CHECK four times -> four grow pulses, score=4, speed_level=2, step period 4 cycles (undefined macro: speed_level=0, period 6).
REQ-041 collision and apple_eaten together in CHECK -> game_over=1, no grow, score unchanged. Then start -> IDLE, score=0.
REQ-042 pause high for 10 cycles mid-RUN -> counter frozen, next step delayed by exactly 10 cycles.
REQ-043 reset_n low during MOVE -> outputs cleared immediately, no grow pulse afterwards.

Source files
------------

// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snake_pkg
// Purpose  : Shared direction/state types and the opposite-direction helper
//            for the snake game sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package snake_pkg;

   typedef enum logic [1:0] {
      DIR_RIGHT = 2'b00,
      DIR_DOWN  = 2'b01,
      DIR_UP    = 2'b10,
      DIR_LEFT  = 2'b11
   } dir_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_MOVE  = 3'd2,
      ST_CHECK = 3'd3,
      ST_OVER  = 3'd4
   } seq_state_t;

   // The encoding pairs opposites as bitwise complements (00/11, 01/10).
   function automatic dir_t opposite_dir(input dir_t d);
      return dir_t'(~d);
   endfunction

endpackage
`default_nettype wire

// File: rtl/snake_step_timer.sv
`default_nettype none
// ============================================================================
// Module   : snake_step_timer
// Purpose  : Game-step period counter. With SNAKE_SPEEDUP_EN defined the
//            period shrinks per speed level down to MIN_DIV.
// Revision : 1.0 - initial release
// ============================================================================
module snake_step_timer #(
   parameter int unsigned TICK_DIV   = 25000000,
   parameter int unsigned MIN_DIV    = 5000000,
   parameter int unsigned SPEED_STEP = 2500000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clear,
   input  logic        enable,
   input  logic [3:0]  speed_level,
   output logic        tick,
   output logic [31:0] period
);

   logic [31:0] r_count;

`ifdef SNAKE_SPEEDUP_EN
   logic [31:0] w_reduce;

   always_comb begin
      w_reduce = 32'(speed_level) * SPEED_STEP;
      // Clamp to MIN_DIV, including reductions that exceed TICK_DIV outright.
      if ((w_reduce < TICK_DIV) && ((TICK_DIV - w_reduce) > MIN_DIV))
         period = TICK_DIV - w_reduce;
      else
         period = MIN_DIV;
   end
`else
   logic w_unused_cfg;
   assign w_unused_cfg = ^{speed_level, MIN_DIV, SPEED_STEP};
   assign period       = TICK_DIV;
`endif

   assign tick = enable && (r_count >= (period - 32'd1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_count <= '0;
      else if (clear || tick)
         r_count <= '0;
      else if (enable)
         r_count <= r_count + 32'd1;
   end

endmodule
`default_nettype wire

// File: rtl/snake_game_seq.sv
`default_nettype none
// ============================================================================
// Module   : snake_game_seq
// Purpose  : Snake game step sequencer (IDLE/RUN/MOVE/CHECK/OVER) with
//            direction filtering, scoring and optional SNAKE_SPEEDUP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module snake_game_seq
   import snake_pkg::*;
#(
   parameter int unsigned TICK_DIV         = 25000000,
   parameter int unsigned MIN_DIV          = 5000000,
   parameter int unsigned SPEED_STEP       = 2500000,
   parameter int unsigned APPLES_PER_LEVEL = 4,
   parameter int unsigned SCORE_W          = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               pause,
   input  logic               dir_req_valid,
   input  logic [1:0]         dir_req,
   input  logic               collision,
   input  logic               apple_eaten,
   output logic               step,
   output logic [1:0]         cur_dir,
   output logic               grow,
   output logic [SCORE_W-1:0] score,
   output logic [3:0]         speed_level,
   output logic               game_over
);

   seq_state_t         r_state;
   dir_t               r_pending;
   dir_t               r_cur_dir;
   logic               r_step;
   logic               r_grow;
   logic               r_game_over;
   logic [SCORE_W-1:0] r_score;

   logic        w_tick;
   logic [31:0] w_unused_period;
   logic        w_clear;
   logic        w_enable;
   logic        w_dir_accept;

   assign w_clear      = (r_state == ST_IDLE) && start;
   assign w_enable     = (r_state == ST_RUN) && !pause;
   assign w_dir_accept = dir_req_valid && (r_state != ST_OVER) &&
                         (dir_t'(dir_req) != opposite_dir(r_cur_dir));

   snake_step_timer #(
      .TICK_DIV   (TICK_DIV),
      .MIN_DIV    (MIN_DIV),
      .SPEED_STEP (SPEED_STEP)
   ) u_step_timer (
      .clk         (clk),
      .reset_n     (reset_n),
      .clear       (w_clear),
      .enable      (w_enable),
      .speed_level (speed_level),
      .tick        (w_tick),
      .period      (w_unused_period)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_pending   <= DIR_RIGHT;
         r_cur_dir   <= DIR_RIGHT;
         r_step      <= 1'b0;
         r_grow      <= 1'b0;
         r_game_over <= 1'b0;
         r_score     <= '0;
      end else begin
         r_step <= 1'b0;
         r_grow <= 1'b0;
         if (w_dir_accept)
            r_pending <= dir_t'(dir_req);
         case (r_state)
            ST_IDLE: begin
               if (start)
                  r_state <= ST_RUN;
            end
            ST_RUN: begin
               // Outputs are registered, so step and cur_dir go live with MOVE.
               if (w_tick) begin
                  r_state   <= ST_MOVE;
                  r_step    <= 1'b1;
                  r_cur_dir <= r_pending;
               end
            end
            ST_MOVE: begin
               r_state <= ST_CHECK;
            end
            ST_CHECK: begin
               if (collision) begin
                  r_state     <= ST_OVER;
                  r_game_over <= 1'b1;
               end else begin
                  r_state <= ST_RUN;
                  if (apple_eaten) begin
                     r_grow <= 1'b1;
                     if (r_score != {SCORE_W{1'b1}})
                        r_score <= r_score + SCORE_W'(1);
                  end
               end
            end
            ST_OVER: begin
               if (start) begin
                  r_state     <= ST_IDLE;
                  r_game_over <= 1'b0;
                  r_score     <= '0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef SNAKE_SPEEDUP_EN
   logic [3:0]  r_speed;
   logic [31:0] r_apple_cnt;
   logic        w_grow_evt;

   assign w_grow_evt = (r_state == ST_CHECK) && !collision && apple_eaten;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_speed     <= 4'd0;
         r_apple_cnt <= 32'd0;
      end else if ((r_state == ST_OVER) && start) begin
         r_speed     <= 4'd0;
         r_apple_cnt <= 32'd0;
      end else if (w_grow_evt) begin
         if (r_apple_cnt >= (APPLES_PER_LEVEL - 32'd1)) begin
            r_apple_cnt <= 32'd0;
            if (r_speed != 4'hF)
               r_speed <= r_speed + 4'd1;
         end else begin
            r_apple_cnt <= r_apple_cnt + 32'd1;
         end
      end
   end

   assign speed_level = r_speed;
`else
   logic w_unused_cfg;
   assign w_unused_cfg = ^APPLES_PER_LEVEL;
   assign speed_level  = 4'd0;
`endif

   assign step      = r_step;
   assign cur_dir   = r_cur_dir;
   assign grow      = r_grow;
   assign score     = r_score;
   assign game_over = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_snake_game_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_game_seq
// Purpose  : Self-checking bench for snake_game_seq with a game-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snake_game_seq;

   localparam int TICK  = 4;
   localparam int MIN   = 2;
   localparam int SSTEP = 1;
   localparam int APL   = 2;
   localparam int SW    = 8;
`ifdef SNAKE_SPEEDUP_EN
   localparam bit SPEEDUP = 1'b1;
`else
   localparam bit SPEEDUP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          pause = 1'b0;
   logic          dir_req_valid = 1'b0;
   logic [1:0]    dir_req = 2'b00;
   logic          collision = 1'b0;
   logic          apple_eaten = 1'b0;
   logic          step;
   logic [1:0]    cur_dir;
   logic          grow;
   logic [SW-1:0] score;
   logic [3:0]    speed_level;
   logic          game_over;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int step_cnt = 0;
   int grow_cnt = 0;
   int last_step = 0;
   int last_int  = 0;

   // Game-level model: applied and pending heading, score, level, apples.
   int         m_score;
   int         m_level;
   int         m_apples;
   logic [1:0] m_dir;
   logic [1:0] m_pending;

   snake_game_seq #(
      .TICK_DIV         (TICK),
      .MIN_DIV          (MIN),
      .SPEED_STEP       (SSTEP),
      .APPLES_PER_LEVEL (APL),
      .SCORE_W          (SW)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .pause         (pause),
      .dir_req_valid (dir_req_valid),
      .dir_req       (dir_req),
      .collision     (collision),
      .apple_eaten   (apple_eaten),
      .step          (step),
      .cur_dir       (cur_dir),
      .grow          (grow),
      .score         (score),
      .speed_level   (speed_level),
      .game_over     (game_over)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (step === 1'b1) step_cnt++;
      if (grow === 1'b1) grow_cnt++;
   end

   function automatic int exp_period(input int lvl);
      int p;
      if (!SPEEDUP) return TICK;
      p = TICK - lvl * SSTEP;
      return (p < MIN) ? MIN : p;
   endfunction

   function automatic logic [1:0] opp(input logic [1:0] d);
      case (d)
         2'b00:   return 2'b11;   // right <-> left
         2'b11:   return 2'b00;
         2'b01:   return 2'b10;   // down <-> up
         default: return 2'b01;
      endcase
   endfunction

   task automatic clk_wait();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_step(output int t, output bit to);
      to = 1'b1;
      t  = 0;
      for (int i = 0; i < 100 && to; i++) begin
         clk_wait();
         if (step === 1'b1) begin
            to = 1'b0;
            t  = cyc;
         end
      end
   endtask

   task automatic model_reset();
      m_score = 0; m_level = 0; m_apples = 0; m_dir = 2'b00; m_pending = 2'b00;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; start = 1'b0; pause = 1'b0; dir_req_valid = 1'b0;
      collision = 1'b0; apple_eaten = 1'b0;
      repeat (2) clk_wait();
      reset_n = 1'b1;
      model_reset();
      clk_wait();
   endtask

   task automatic begin_game(output int s);
      start = 1'b1;
      clk_wait();
      start = 1'b0;
      s = cyc;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #3;
      n_checks++;
      if ({step, grow, game_over, score, speed_level, cur_dir} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: step=%b grow=%b over=%b score=%0d lvl=%0d dir=%b required all zero",
                  step, grow, game_over, score, speed_level, cur_dir);
      end
      repeat (2) clk_wait();
      reset_n = 1'b1;
      model_reset();
      repeat (8) clk_wait();
      n_checks++;
      if (step_cnt != 0 || game_over !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_quiet: steps=%0d over=%b required 0 and 0", step_cnt, game_over);
      end
   endtask

   task automatic test_start_period();
      int s; int t; bit to;
      begin_game(s);
      wait_step(t, to);
      n_checks++;
      if (to || t != s + exp_period(m_level)) begin
         n_fail++;
         $display("FAIL first_step: at cycle %0d (timeout=%b) required %0d", t, to, s + exp_period(m_level));
      end
      n_checks++;
      if (cur_dir !== 2'b00 || score !== 8'd0) begin
         n_fail++;
         $display("FAIL first_step_state: dir=%b score=%0d required 00 and 0", cur_dir, score);
      end
      last_step = t;
      for (int i = 0; i < 3; i++) begin
         wait_step(t, to);
         n_checks++;
         if (to || t - last_step != exp_period(m_level) + 2) begin
            n_fail++;
            $display("FAIL step_period%0d: interval %0d (timeout=%b) required %0d",
                     i, t - last_step, to, exp_period(m_level) + 2);
         end
         last_step = t;
      end
   endtask

   task automatic test_dir_filter();
      int t; bit to;
      apple_eaten = 1'b0;
      dir_req = 2'b11; dir_req_valid = 1'b1;
      if (2'b11 != opp(m_dir)) m_pending = 2'b11;
      clk_wait();
      dir_req_valid = 1'b0;
      wait_step(t, to);
      m_dir = m_pending;
      n_checks++;
      if (to || cur_dir !== m_dir) begin
         n_fail++;
         $display("FAIL dir_opposite_drop: dir=%b (timeout=%b) required %b", cur_dir, to, m_dir);
      end
      last_step = t;
      dir_req = 2'b01; dir_req_valid = 1'b1;
      if (2'b01 != opp(m_dir)) m_pending = 2'b01;
      clk_wait();
      dir_req = 2'b10;
      if (2'b10 != opp(m_dir)) m_pending = 2'b10;
      clk_wait();
      dir_req_valid = 1'b0;
      wait_step(t, to);
      m_dir = m_pending;
      n_checks++;
      if (to || cur_dir !== m_dir) begin
         n_fail++;
         $display("FAIL dir_last_wins: dir=%b (timeout=%b) required %b", cur_dir, to, m_dir);
      end
      last_step = t;
   endtask

   task automatic test_random_play(input int nsteps, input int apple_pct);
      bit a; int nreq; int t; bit to; logic [1:0] r;
      for (int i = 0; i < nsteps; i++) begin
         a = ($urandom_range(99) < apple_pct);
         apple_eaten = a;
         nreq = $urandom_range(2);
         for (int j = 0; j < nreq; j++) begin
            r = 2'($urandom_range(3));
            dir_req = r; dir_req_valid = 1'b1;
            if (r != opp(m_dir)) m_pending = r;
            clk_wait();
         end
         dir_req_valid = 1'b0;
         while (cyc < last_step + 2) clk_wait();
         n_checks++;
         if (grow !== a) begin
            n_fail++;
            $display("FAIL play_grow step%0d: grow=%b required %b", i, grow, a);
         end
         if (a) begin
            if (m_score < (1 << SW) - 1) m_score++;
            m_apples++;
            if (SPEEDUP && (m_apples % APL == 0) && m_level < 15) m_level++;
         end
         n_checks++;
         if (score !== 8'(m_score) || speed_level !== 4'(m_level) || game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL play_score step%0d: score=%0d lvl=%0d over=%b required %0d %0d 0",
                     i, score, speed_level, game_over, m_score, m_level);
         end
         apple_eaten = 1'($urandom_range(1));
         wait_step(t, to);
         n_checks++;
         if (to) begin
            n_fail++;
            $display("FAIL play_step_timeout step%0d: no step within bound, required one", i);
            last_step = cyc;
         end else begin
            m_dir = m_pending;
            if (t - last_step != exp_period(m_level) + 2 || cur_dir !== m_dir) begin
               n_fail++;
               $display("FAIL play_step step%0d: interval %0d dir=%b required %0d dir=%b",
                        i, t - last_step, cur_dir, exp_period(m_level) + 2, m_dir);
            end
            last_int  = t - last_step;
            last_step = t;
         end
      end
   endtask

   task automatic test_pause();
      int k; int t; bit to;
      apple_eaten = 1'b0;
      k = last_step;
      while (cyc < k + 2) clk_wait();
      pause = 1'b1;
      start = 1'b1;
      clk_wait();
      start = 1'b0;
      repeat (9) clk_wait();
      pause = 1'b0;
      wait_step(t, to);
      m_dir = m_pending;
      n_checks++;
      if (to || t - k != exp_period(m_level) + 2 + 10) begin
         n_fail++;
         $display("FAIL pause_delay: interval %0d (timeout=%b) required %0d",
                  t - k, to, exp_period(m_level) + 12);
      end
      n_checks++;
      if (cur_dir !== m_dir) begin
         n_fail++;
         $display("FAIL pause_dir: dir=%b required %b", cur_dir, m_dir);
      end
      last_step = t;
   endtask

   task automatic test_collision();
      int s; int t; bit to; int sc; int gc; logic [1:0] r;
      collision = 1'b1; apple_eaten = 1'b1;
      while (cyc < last_step + 2) clk_wait();
      n_checks++;
      if (game_over !== 1'b1 || grow !== 1'b0 || score !== 8'(m_score)) begin
         n_fail++;
         $display("FAIL collision_wins: over=%b grow=%b score=%0d required 1 0 %0d",
                  game_over, grow, score, m_score);
      end
      collision = 1'b0; apple_eaten = 1'b0;
      sc = step_cnt; gc = grow_cnt;
      r = m_pending ^ 2'b01;
      dir_req = r; dir_req_valid = 1'b1;
      clk_wait();
      dir_req_valid = 1'b0;
      repeat (12) clk_wait();
      n_checks++;
      if (step_cnt != sc || grow_cnt != gc || game_over !== 1'b1) begin
         n_fail++;
         $display("FAIL over_hold: steps+%0d grows+%0d over=%b required 0 0 1",
                  step_cnt - sc, grow_cnt - gc, game_over);
      end
      start = 1'b1;
      clk_wait();
      start = 1'b0;
      m_score = 0; m_level = 0; m_apples = 0;
      n_checks++;
      if (game_over !== 1'b0 || score !== 8'd0 || speed_level !== 4'd0) begin
         n_fail++;
         $display("FAIL over_restart: over=%b score=%0d lvl=%0d required 0 0 0",
                  game_over, score, speed_level);
      end
      r = m_pending ^ 2'b01;
      dir_req = r; dir_req_valid = 1'b1;
      if (r != opp(m_dir)) m_pending = r;
      clk_wait();
      dir_req_valid = 1'b0;
      begin_game(s);
      wait_step(t, to);
      m_dir = m_pending;
      n_checks++;
      if (to || t != s + exp_period(0) || cur_dir !== m_dir) begin
         n_fail++;
         $display("FAIL new_game_step: at %0d dir=%b (timeout=%b) required %0d dir=%b",
                  t, cur_dir, to, s + exp_period(0), m_dir);
      end
      last_step = t;
   endtask

   task automatic test_reset_in_move();
      int sc; int gc;
      apple_eaten = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if ({step, grow, game_over, score, speed_level, cur_dir} !== '0) begin
         n_fail++;
         $display("FAIL reset_in_move: step=%b grow=%b over=%b score=%0d lvl=%0d dir=%b required all zero",
                  step, grow, game_over, score, speed_level, cur_dir);
      end
      sc = step_cnt; gc = grow_cnt;
      clk_wait();
      reset_n = 1'b1;
      model_reset();
      repeat (20) clk_wait();
      apple_eaten = 1'b0;
      n_checks++;
      if (step_cnt != sc || grow_cnt != gc) begin
         n_fail++;
         $display("FAIL reset_abandon: steps+%0d grows+%0d required 0 0", step_cnt - sc, grow_cnt - gc);
      end
   endtask

   task automatic test_apples();
      int s; int t; bit to;
      do_reset();
      begin_game(s);
      wait_step(t, to);
      n_checks++;
      if (to || t != s + exp_period(0)) begin
         n_fail++;
         $display("FAIL apples_first_step: at %0d (timeout=%b) required %0d", t, to, s + exp_period(0));
      end
      last_step = t;
      test_random_play(4, 100);
      n_checks++;
      if (score !== 8'd4 || speed_level !== (SPEEDUP ? 4'd2 : 4'd0) || last_int != (SPEEDUP ? 4 : 6)) begin
         n_fail++;
         $display("FAIL apples_four: score=%0d lvl=%0d interval=%0d required 4 %0d %0d",
                  score, speed_level, last_int, SPEEDUP ? 2 : 0, SPEEDUP ? 4 : 6);
      end
   endtask

   task automatic test_saturation();
      int s; int t; bit to;
      do_reset();
      begin_game(s);
      wait_step(t, to);
      last_step = t;
      test_random_play(262, 100);
      n_checks++;
      if (score !== 8'hFF || speed_level !== (SPEEDUP ? 4'hF : 4'h0)) begin
         n_fail++;
         $display("FAIL saturation: score=%0d lvl=%0d required 255 %0d", score, speed_level, SPEEDUP ? 15 : 0);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_start_period();
      test_dir_filter();
      test_random_play(30, 50);
      test_pause();
      test_collision();
      test_random_play(10, 60);
      test_reset_in_move();
      test_apples();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
